// File: rtl/mdl_oob_seq.sv
// SATA device-side OOB sequencer: COMINIT bursts, COMWAKE wait and bursts, then ALIGN/SYNC.
// Optional COMWAKE timeout/retry enabled by defining OOB_RETRY_EN.
module mdl_oob_seq #(
  parameter int BURST_LEN = 160,
  parameter int CI_IDLE   = 480,
  parameter int CW_IDLE   = 160,
  parameter int N_BURST   = 6,
  parameter int ALIGN_MIN = 256,
  parameter int PRIM_CYC  = 1,
  parameter int RETRY_TMO = 4096
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_comreset_det,
  input  logic        i_comwake_det,
  input  logic        i_oob_done,
  output logic        o_burst_en,
  output logic [39:0] o_data,
  output logic        o_prim_stb,
  output logic [2:0]  o_state,
  output logic        o_done,
  output logic [3:0]  o_retry_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_CI_TX = 3'd1, S_CW_WAIT = 3'd2,
    S_CW_TX = 3'd3, S_ALIGN = 3'd4, S_SYNC = 3'd5
  } state_t;

  // 10b symbols, K28.x first on the wire in bits [9:0], running disparity starting negative
  localparam logic [39:0] ALIGN_P = {10'b0010011100, 10'b0101010101, 10'b0101010101, 10'b0011111010};
  localparam logic [39:0] SYNC_P  = {10'b1010101010, 10'b1010101010, 10'b1010100010, 10'b0011110011};

  localparam int CI_PER  = BURST_LEN + CI_IDLE;
  localparam int CW_PER  = BURST_LEN + CW_IDLE;
  localparam int PER_MAX = (CI_PER > CW_PER) ? CI_PER : CW_PER;
  localparam int CYC_W   = $clog2(PER_MAX) + 1;
  localparam int BST_W   = $clog2(N_BURST) + 1;
  localparam int PRM_W   = $clog2(PRIM_CYC) + 1;
  localparam int ALN_W   = $clog2(ALIGN_MIN) + 1;

  state_t             state;
  logic [CYC_W-1:0]   cyc;
  logic [BST_W-1:0]   bst;
  logic [PRM_W-1:0]   pcnt;
  logic [ALN_W-1:0]   acnt;
  logic [ALN_W-1:0]   acnt_nxt;
  logic [CYC_W-1:0]   per_last;
  logic               sticky;
  logic               prim_last;

  always_comb begin
    acnt_nxt  = (acnt == ALN_W'(ALIGN_MIN)) ? acnt : acnt + 1'b1;
    per_last  = (state == S_CI_TX) ? CYC_W'(CI_PER - 1) : CYC_W'(CW_PER - 1);
    prim_last = (pcnt == PRM_W'(PRIM_CYC - 1));
  end

`ifdef OOB_RETRY_EN
  localparam int TMO_W = $clog2(RETRY_TMO) + 1;
  logic [TMO_W-1:0] tmo;
  logic [3:0]       retry;
  assign o_retry_cnt = retry;
`else
  assign o_retry_cnt = 4'd0;
`endif

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= S_IDLE; o_burst_en <= 1'b0; o_prim_stb <= 1'b0; o_done <= 1'b0;
      o_data <= ALIGN_P; cyc <= '0; bst <= '0; pcnt <= '0; acnt <= '0; sticky <= 1'b0;
`ifdef OOB_RETRY_EN
      tmo <= '0; retry <= 4'd0;
`endif
    end else if (i_comreset_det) begin
      // COMRESET from any state restarts COMINIT at burst 1, cycle 0
      state <= S_CI_TX; o_burst_en <= 1'b1; o_prim_stb <= 1'b1; o_done <= 1'b0;
      o_data <= ALIGN_P; cyc <= '0; bst <= '0; pcnt <= '0; acnt <= '0; sticky <= 1'b0;
`ifdef OOB_RETRY_EN
      tmo <= '0;
`endif
    end else begin
      o_prim_stb <= 1'b0;
      case (state)
        S_IDLE: ;
        S_CI_TX, S_CW_TX: begin
          if (cyc == per_last) begin
            cyc <= '0; pcnt <= '0;
            if (bst == BST_W'(N_BURST - 1)) begin
              bst <= '0;
              if (state == S_CI_TX) begin
                state <= S_CW_WAIT; o_burst_en <= 1'b0;
              end else begin
                state <= S_ALIGN; o_burst_en <= 1'b1; o_prim_stb <= 1'b1; o_done <= 1'b1;
              end
            end else begin
              bst <= bst + 1'b1; o_burst_en <= 1'b1; o_prim_stb <= 1'b1;
            end
          end else begin
            cyc <= cyc + 1'b1;
            if (cyc < CYC_W'(BURST_LEN - 1)) begin
              o_burst_en <= 1'b1;
              if (prim_last) begin pcnt <= '0; o_prim_stb <= 1'b1; end
              else pcnt <= pcnt + 1'b1;
            end else begin
              o_burst_en <= 1'b0;
            end
          end
        end
        S_CW_WAIT: begin
          if (i_comwake_det) begin
            state <= S_CW_TX; o_burst_en <= 1'b1; o_prim_stb <= 1'b1;
            cyc <= '0; bst <= '0; pcnt <= '0;
`ifdef OOB_RETRY_EN
            tmo <= '0;
          end else if (tmo == TMO_W'(RETRY_TMO - 1)) begin
            state <= S_CI_TX; o_burst_en <= 1'b1; o_prim_stb <= 1'b1;
            cyc <= '0; bst <= '0; pcnt <= '0; tmo <= '0;
            if (retry != 4'hf) retry <= retry + 4'd1;
          end else begin
            tmo <= tmo + 1'b1;
`endif
          end
        end
        S_ALIGN: begin
          if (i_oob_done) sticky <= 1'b1;
          if (prim_last) begin
            pcnt <= '0; o_prim_stb <= 1'b1; acnt <= acnt_nxt;
            // switch only on a primitive boundary once enough ALIGNs went out
            if (acnt_nxt == ALN_W'(ALIGN_MIN) && (sticky || i_oob_done)) begin
              state <= S_SYNC; o_data <= SYNC_P; sticky <= 1'b0;
            end
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        S_SYNC: begin
          if (prim_last) begin pcnt <= '0; o_prim_stb <= 1'b1; end
          else pcnt <= pcnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_state = state;

endmodule

// File: doc/mdl_oob_seq.md
MDL_OOB_SEQ -- requirements
Module: mdl_oob_seq

Interface
REQ-001 SHALL have parameter BURST_LEN, default 160: cycles per OOB burst (o_burst_en high).
REQ-002 SHALL have parameter CI_IDLE, default 480: idle cycles after each COMINIT burst.
REQ-003 SHALL have parameter CW_IDLE, default 160: idle cycles after each COMWAKE burst.
REQ-004 SHALL have parameter N_BURST, default 6: bursts per COMINIT/COMWAKE sequence.
REQ-005 SHALL have parameter ALIGN_MIN, default 256: minimum ALIGN primitives before SYNC is allowed.
REQ-006 SHALL have parameter PRIM_CYC, default 1: cycles per 40-bit primitive word.
REQ-007 SHALL have parameter RETRY_TMO, default 4096: COMWAKE wait timeout in cycles (used only under OOB_RETRY_EN).
REQ-008 SHALL have port i_clk, input, 1: sole clock.
REQ-009 SHALL have port i_reset_n, input, 1: reset, asynchronous, active-low.
REQ-010 SHALL have port i_comreset_det, input, 1: host COMRESET detected.
REQ-011 SHALL have port i_comwake_det, input, 1: host COMWAKE detected.
REQ-012 SHALL have port i_oob_done, input, 1: host reports its OOB complete.
REQ-013 SHALL have port o_burst_en, output, 1: transmitter enable; low = electrical idle.
REQ-014 SHALL have port o_data, output, 40: primitive word, K28.5 or K28.3 in bits [9:0].
REQ-015 SHALL have port o_prim_stb, output, 1: one-cycle strobe at the first cycle of each primitive.
REQ-016 SHALL have port o_state, output, 3: current FSM state encoding.
REQ-017 SHALL have port o_done, output, 1: OOB complete; ALIGN or SYNC in progress.
REQ-018 SHALL have port o_retry_cnt, output, 4: saturating COMINIT retry count.

Function
REQ-019 SHALL implement states IDLE=0, CI_TX=1, CW_WAIT=2, CW_TX=3, ALIGN=4, SYNC=5.
REQ-020 SHALL, in IDLE, move to CI_TX on the cycle after i_comreset_det is sampled high; o_burst_en SHALL go high in that same first CI_TX cycle.
REQ-021 SHALL, in CI_TX, emit N_BURST periods, each BURST_LEN cycles with o_burst_en=1 followed by CI_IDLE cycles with o_burst_en=0, then enter CW_WAIT; total N_BURST*(BURST_LEN+CI_IDLE) cycles.
REQ-022 SHALL, in CW_WAIT, hold o_burst_en=0 and move to CW_TX on the cycle after i_comwake_det is sampled high.
REQ-023 SHALL, in CW_TX, emit N_BURST periods of BURST_LEN burst cycles plus CW_IDLE idle cycles, then enter ALIGN.
REQ-024 SHALL, during every burst and in ALIGN, drive o_data = ALIGN_P = {D27.3, D10.2, D10.2, K28.5}.
REQ-025 SHALL, in SYNC, drive o_data = SYNC_P = {D21.5, D21.5, D21.4, K28.3}.
REQ-026 SHALL hold o_burst_en=1 continuously in ALIGN and SYNC, with o_prim_stb pulsing every PRIM_CYC cycles.
REQ-027 SHALL count ALIGN primitives, saturating at ALIGN_MIN.
REQ-028 SHALL leave ALIGN for SYNC only at a primitive boundary where i_oob_done=1 and the count has reached ALIGN_MIN.
REQ-029 SHALL hold an early i_oob_done as a sticky flag until the SYNC transition completes.
REQ-030 SHALL remain in SYNC until reset or COMRESET.
REQ-031 SHALL, when i_comreset_det is high in any state other than IDLE, restart CI_TX from burst 1 cycle 0 on the next cycle.
REQ-032 SHALL, on that COMRESET restart, clear all counters and the sticky flag, and hold o_done=0.
REQ-033 SHALL ignore i_comwake_det outside CW_WAIT.
REQ-034 SHALL give i_comreset_det priority over i_comwake_det when both are high in CW_WAIT.
REQ-035 SHALL assert o_done exactly in ALIGN and SYNC.
REQ-036 SHALL size every counter as $clog2 of its maximum value plus 1 bit, with no wrap inside a phase.

Reset
REQ-037 SHALL, while i_reset_n=0, asynchronously force state IDLE, o_burst_en=0, o_prim_stb=0, o_done=0, o_retry_cnt=0, o_data=ALIGN_P, all counters 0 and the sticky flag 0.
REQ-038 SHALL, after i_reset_n deasserts, leave IDLE no earlier than the first clock edge.

Configuration
REQ-039 SHALL, with OOB_RETRY_EN defined, return from CW_WAIT to CI_TX if RETRY_TMO cycles pass without i_comwake_det.
REQ-040 SHALL, with OOB_RETRY_EN defined, increment o_retry_cnt (saturating at 15) on each such timeout.
REQ-041 SHALL, without OOB_RETRY_EN, wait in CW_WAIT indefinitely, tie o_retry_cnt to 0, and omit the timeout counter.

Verification
REQ-042 SHALL verify: BURST_LEN=4, CI_IDLE=12, N_BURST=6, 1-cycle i_comreset_det -> 6 bursts of 4 high / 12 low, CW_WAIT entered 96 cycles after CI_TX entry.
REQ-043 SHALL verify: CW_IDLE=4, i_comwake_det in CW_WAIT -> 6 bursts of 4/4, ALIGN after 48 cycles, o_done=1, o_data[9:0]=10'b0011111010.
REQ-044 SHALL verify: ALIGN_MIN=8, PRIM_CYC=4, i_oob_done at the 2nd primitive -> SYNC entered at the 9th primitive boundary, o_data[9:0]=10'b0011110011.
REQ-045 SHALL verify: i_comreset_det during CW_TX burst 3 -> CI_TX restarts at burst 1, o_done=0, o_burst_en high the next cycle.
REQ-046 SHALL verify: OOB_RETRY_EN, RETRY_TMO=100, no COMWAKE -> back to CI_TX after 100 cycles, o_retry_cnt=1; without the macro, still in CW_WAIT after 1000 cycles.
REQ-047 SHALL verify: i_reset_n low mid-ALIGN, asynchronously between edges -> outputs take reset values immediately, state=IDLE.
